// File: rtl/rfphoenix_mp_scoreboard_pkg.sv
// rfphoenix_mp_scoreboard_pkg: register spec, decode bus and scoreboard history types.
package rfphoenix_mp_scoreboard_pkg;
  typedef struct packed {
    logic       vec;
    logic [5:0] num;
  } regspec_t;
  localparam int SB_NREGS = 128;
  localparam int SB_CNTW = 2;
  localparam int SB_HIST = 5;
  localparam int RSW = $bits(regspec_t);
  typedef logic [SB_NREGS-1:0] regs_bitmap_t;
  typedef struct packed {
    logic     v, hasRa, hasRb, hasRc, hasRm, hasRt;
    regspec_t Ra, Rb, Rc, Rm, Rt;
    logic     rfwr, vrfwr;
  } decode_bus_t;
  typedef struct packed {
    logic     v;
    regspec_t Rt;
  } sb_hist_t;
  // A target only counts if the matching register file is written and it is not r0.
  function automatic logic tgt_valid(input decode_bus_t d);
    return d.v & d.hasRt & ((d.rfwr & ~d.Rt.vec) | (d.vrfwr & d.Rt.vec)) & (d.Rt != '0);
  endfunction
endpackage

// File: rtl/rfphoenix_mp_scoreboard_counter.sv
// rfphoenix_sb_counter: saturating pending-write counter, +0/1 and -0..(2**DW-1) per cycle.
module rfphoenix_sb_counter #(
  parameter int CNTW = 2,
  parameter int DW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic [DW-1:0]   i_dec,
  output logic [CNTW-1:0] o_cnt,
  output logic            o_nz,
  output logic            o_sat,
  output logic            o_err
);
  localparam int SW = CNTW + DW + 1;
  localparam logic signed [SW-1:0] S_MAX = SW'(2**CNTW - 1);
  logic [CNTW-1:0]        r_cnt;
  logic signed [SW-1:0]   w_sum;
  logic                   w_lo, w_hi;
  logic [CNTW-1:0]        w_next;
  always_comb begin
    w_sum  = $signed({{(SW-CNTW){1'b0}}, r_cnt}) + $signed({{(SW-1){1'b0}}, i_inc})
           - $signed({{(SW-DW){1'b0}}, i_dec});
    w_lo   = w_sum[SW-1];
    w_hi   = ~w_lo && (w_sum > S_MAX);
    w_next = w_lo ? '0 : w_hi ? '1 : w_sum[CNTW-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_next;
  assign o_cnt = r_cnt;
  assign o_nz  = |r_cnt;
  assign o_sat = &r_cnt;
  assign o_err = w_lo | w_hi;
endmodule

// File: rtl/rfphoenix_mp_scoreboard.sv
// rfphoenix_mp_scoreboard: counting register scoreboard with multi-port writeback and
// history-based rollback cancellation of squashed in-flight targets.
module rfphoenix_mp_scoreboard
  import rfphoenix_mp_scoreboard_pkg::*;
#(
  parameter int NREGS  = SB_NREGS,
  parameter int NWB    = 2,
  parameter int CNTW   = SB_CNTW,
  parameter int HIST   = SB_HIST,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  decode_bus_t           i_db,
  input  logic                  i_will_issue,
  input  logic [NWB-1:0]        i_wb_v,
  input  regspec_t [NWB-1:0]    i_wb_Rt,
  input  logic                  i_rollback,
  input  logic [HIST-1:0]       i_rollback_mask,
  output logic                  o_can_issue,
  output logic [NREGS-1:0]      o_busy,
  output logic                  o_sb_err
);
  localparam int DW = $clog2(NWB + HIST + 1);
  sb_hist_t         r_hist [HIST];
  logic             r_err;
  logic [CNTW-1:0]  w_cnt [NREGS];
  logic [NREGS-1:0] w_nz, w_sat, w_err;
  regspec_t         w_src [4];
  logic [3:0]       w_has, w_rdy;
  logic [RSW-1:0]   w_rt;
  logic             w_tv, w_issue;
  genvar s, r;
  assign w_tv  = tgt_valid(i_db);
  assign w_rt  = i_db.Rt;
  assign w_src = '{i_db.Ra, i_db.Rb, i_db.Rc, i_db.Rm};
  assign w_has = {i_db.hasRm, i_db.hasRc, i_db.hasRb, i_db.hasRa};
  for (s = 0; s < 4; s++) begin : g_src
    logic [RSW-1:0] w_idx;
    logic           w_hit;
    assign w_idx = w_src[s];
    always_comb begin
      w_hit = 1'b0;
      for (int k = 0; k < NWB; k++) w_hit |= i_wb_v[k] && (i_wb_Rt[k] == w_idx);
    end
    // The last outstanding write landing this cycle can be forwarded.
    assign w_rdy[s] = ~w_has[s] || (w_idx == '0) || (w_cnt[w_idx] == '0) ||
                      (BYPASS && (w_cnt[w_idx] == CNTW'(1)) && w_hit);
  end
  assign o_can_issue = ~rst & i_db.v & ~i_rollback & (&w_rdy) & (~w_tv | ~w_sat[w_rt]);
  assign w_issue     = i_will_issue & o_can_issue & w_tv;
  assign w_cnt[0] = '0;
  assign w_nz[0]  = 1'b0;
  assign w_sat[0] = 1'b0;
  assign w_err[0] = 1'b0;
  for (r = 1; r < NREGS; r++) begin : g_reg
    logic [DW-1:0] w_dec;
    always_comb begin
      w_dec = '0;
      for (int k = 0; k < NWB; k++)
        w_dec += DW'(i_wb_v[k] && (i_wb_Rt[k] == RSW'(r)));
      for (int h = 0; h < HIST; h++)
        w_dec += DW'(i_rollback && i_rollback_mask[h] && r_hist[h].v && (r_hist[h].Rt == RSW'(r)));
    end
    rfphoenix_sb_counter #(.CNTW(CNTW), .DW(DW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_issue && (w_rt == RSW'(r))),
      .i_dec (w_dec),
      .o_cnt (w_cnt[r]),
      .o_nz  (w_nz[r]),
      .o_sat (w_sat[r]),
      .o_err (w_err[r])
    );
  end
  // Cancelled entries are invalidated as they shift so they cannot be cancelled twice.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int h = 0; h < HIST; h++) r_hist[h] <= '0;
      r_err <= 1'b0;
    end else begin
      r_hist[0].v  <= w_issue;
      r_hist[0].Rt <= i_db.Rt;
      for (int h = 1; h < HIST; h++) begin
        r_hist[h].v  <= r_hist[h-1].v & ~(i_rollback & i_rollback_mask[h-1]);
        r_hist[h].Rt <= r_hist[h-1].Rt;
      end
      r_err <= r_err | (|w_err);
    end
  assign o_busy   = w_nz;
  assign o_sb_err = r_err;
endmodule

// File: tb/tb_rfphoenix_mp_scoreboard.sv
// tb_rfphoenix_mp_scoreboard: directed scenario bench for the counting scoreboard.
module tb_rfphoenix_mp_scoreboard;
  import rfphoenix_mp_scoreboard_pkg::*;
  logic           clk = 1'b0;
  logic           rst = 1'b0;
  decode_bus_t    db;
  logic           will_issue;
  logic [1:0]     wb_v;
  regspec_t [1:0] wb_Rt;
  logic           rollback;
  logic [4:0]     rollback_mask;
  logic           can_issue;
  logic [127:0]   busy;
  logic           sb_err;
  int total = 0;
  int bad = 0;

  rfphoenix_mp_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .i_db            (db),
    .i_will_issue    (will_issue),
    .i_wb_v          (wb_v),
    .i_wb_Rt         (wb_Rt),
    .i_rollback      (rollback),
    .i_rollback_mask (rollback_mask),
    .o_can_issue     (can_issue),
    .o_busy          (busy),
    .o_sb_err        (sb_err)
  );

  always #5 clk = ~clk;

  function automatic decode_bus_t mk(input logic [6:0] ra, input logic [6:0] rt);
    decode_bus_t d = '0;
    d.v = 1'b1; d.hasRa = (ra != 0); d.Ra = ra; d.hasRt = 1'b1; d.Rt = rt; d.rfwr = 1'b1;
    return d;
  endfunction

  task automatic idle();
    db = '0; will_issue = 0; wb_v = '0; wb_Rt = '0; rollback = 0; rollback_mask = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; #1;
    step(); rst = 0; #1;
  endtask

  task automatic test_reset();
    idle(); db = mk(0, 3); rst = 1; #1;
    total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL rst_can_issue got=%b exp=0", can_issue); end
    total++; if (busy !== '0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL rst_sb_err got=%b exp=0", sb_err); end
    step(); rst = 0; #1;
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL rst_release_can_issue got=%b exp=1", can_issue); end
  endtask

  task automatic test_bypass();
    do_reset();
    db = mk(1, 5); will_issue = 1; #1;
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL byp_first_issue got=%b exp=1", can_issue); end
    step(); idle(); db = mk(5, 6); #1;
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL byp_busy5_set got=%b exp=1", busy[5]); end
    total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL byp_raw_stall got=%b exp=0", can_issue); end
    wb_v = 2'b01; wb_Rt[0] = 7'd5; #1;
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL byp_same_cycle got=%b exp=1", can_issue); end
    step(); idle(); #1;
    total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL byp_busy5_clear got=%b exp=0", busy[5]); end
  endtask

  task automatic test_waw();
    do_reset();
    db = mk(0, 9); will_issue = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL waw_issue%0d got=%b exp=1", i, can_issue); end
      step();
    end
    #1;
    total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL waw_saturated got=%b exp=0", can_issue); end
    step();
    will_issue = 0; db = '0; wb_v = 2'b11; wb_Rt[0] = 7'd9; wb_Rt[1] = 7'd9;
    step(); idle(); db = mk(0, 9); #1;
    total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL waw_busy9_after_2wb got=%b exp=1", busy[9]); end
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL waw_unsat got=%b exp=1", can_issue); end
    db = '0; wb_v = 2'b10; wb_Rt[1] = 7'd9;
    step(); idle(); #1;
    total++; if (busy[9] !== 1'b0) begin bad++; $display("FAIL waw_busy9_drained got=%b exp=0", busy[9]); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL waw_sb_err got=%b exp=0", sb_err); end
  endtask

  task automatic test_rollback();
    do_reset();
    will_issue = 1;
    db = mk(0, 7); step();
    db = mk(0, 8); step();
    db = mk(0, 9); step();
    idle(); rollback = 1; rollback_mask = 5'b00011; step();
    idle(); #1;
    total++; if (busy[15:0] !== 16'h0080) begin bad++; $display("FAIL rb_busy_low got=%h exp=0080", busy[15:0]); end
    rollback = 1; rollback_mask = 5'b01000; step();
    idle(); #1;
    total++; if (busy[7] !== 1'b0) begin bad++; $display("FAIL rb_old_entry got=%b exp=0", busy[7]); end
    rollback = 1; rollback_mask = 5'b01110; step();
    idle(); #1;
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL rb_no_double_cancel got=%b exp=0", sb_err); end
  endtask

  task automatic test_rb_issue();
    do_reset();
    db = mk(0, 12); will_issue = 1; rollback = 1; rollback_mask = '0; #1;
    total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL rbi_can_issue got=%b exp=0", can_issue); end
    step(); idle(); #1;
    total++; if (busy[12] !== 1'b0) begin bad++; $display("FAIL rbi_busy12 got=%b exp=0", busy[12]); end
    rollback = 1; rollback_mask = 5'b00001; step(); idle(); #1;
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL rbi_entry0_invalid got=%b exp=0", sb_err); end
  endtask

  task automatic test_err();
    do_reset();
    wb_v = 2'b01; wb_Rt[0] = 7'd20; step(); idle(); #1;
    total++; if (busy[20] !== 1'b0) begin bad++; $display("FAIL err_busy20 got=%b exp=0", busy[20]); end
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", sb_err); end
    db = mk(0, 21); will_issue = 1; step(); idle(); step();
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", sb_err); end
    do_reset();
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", sb_err); end
  endtask

  task automatic test_midrst_r0();
    do_reset();
    will_issue = 1;
    for (int r = 2; r <= 4; r++) begin
      db = mk(0, 7'(r));
      repeat (3) step();
    end
    idle(); #1;
    total++; if (busy[4:2] !== 3'b111) begin bad++; $display("FAIL mr_busy_pre got=%b exp=111", busy[4:2]); end
    db = mk(2, 10); #1;
    total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL mr_stall_pre got=%b exp=0", can_issue); end
    rst = 1; #1;
    total++; if (busy !== '0) begin bad++; $display("FAIL mr_busy_in_rst got=%h exp=0", busy); end
    total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL mr_can_issue_in_rst got=%b exp=0", can_issue); end
    step(); rst = 0; #1;
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL mr_can_issue_after got=%b exp=1", can_issue); end
    db = mk(0, 0); db.hasRa = 1; will_issue = 1; #1;
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL r0_no_stall got=%b exp=1", can_issue); end
    step();
    db = mk(0, 7'h45); step();
    idle(); wb_v = 2'b11; wb_Rt = '0; step(); idle(); #1;
    total++; if (busy !== '0) begin bad++; $display("FAIL r0_vec_busy got=%h exp=0", busy); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL r0_wb_err got=%b exp=0", sb_err); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_bypass();
    test_waw();
    test_rollback();
    test_rb_issue();
    test_err();
    test_midrst_r0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
